// File: rtl/mem_access_ctrl.sv
// Request sequencer in front of a single-port data memory: turns load/store bursts into
// fixed-timing address/data/strobe sequences and returns responses over a backpressured channel.
module mem_access_ctrl #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [1:0]        req_len,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_last,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data_in,
    output logic              mem_read_write,
    input  logic [DATA_W-1:0] mem_data_out
);

    localparam logic [1:0] WaitInit = 2'(RD_LAT);

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StStrobe,
        StWait,
        StResp,
        StWack
    } state_t;

    state_t            state_q;
    logic              write_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [1:0]        len_q;
    logic [1:0]        beat_q;
    logic [1:0]        wait_q;
    logic              last_beat;

    assign last_beat = (beat_q == len_q);

    // Every output is a flop so the memory sees clean, glitch-free address/data/strobe lines.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= StIdle;
            write_q        <= 1'b0;
            addr_q         <= '0;
            wdata_q        <= '0;
            len_q          <= 2'd0;
            beat_q         <= 2'd0;
            wait_q         <= 2'd0;
            req_ready      <= 1'b1;
            busy           <= 1'b0;
            rsp_valid      <= 1'b0;
            rsp_rdata      <= '0;
            rsp_last       <= 1'b0;
            mem_addr       <= '0;
            mem_data_in    <= '0;
            mem_read_write <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (req_valid && req_ready) begin
                        write_q        <= req_write;
                        addr_q         <= req_addr;
                        wdata_q        <= req_wdata;
                        len_q          <= req_len;
                        beat_q         <= 2'd0;
                        mem_addr       <= req_addr;
                        mem_data_in    <= req_wdata;
                        mem_read_write <= 1'b0;
                        req_ready      <= 1'b0;
                        busy           <= 1'b1;
                        state_q        <= StSetup;
                    end
                end

                StSetup: begin
                    if (write_q) begin
                        mem_read_write <= 1'b1;
                        state_q        <= StStrobe;
                    end else begin
                        wait_q  <= WaitInit;
                        state_q <= StWait;
                    end
                end

                StStrobe: begin
                    mem_read_write <= 1'b0;
                    if (last_beat) begin
                        rsp_valid <= 1'b1;
                        rsp_last  <= 1'b1;
                        rsp_rdata <= '0;
                        state_q   <= StWack;
                    end else begin
                        beat_q      <= beat_q + 2'd1;
                        addr_q      <= addr_q + ADDR_W'(1);
                        wdata_q     <= wdata_q + DATA_W'(1);
                        mem_addr    <= addr_q + ADDR_W'(1);
                        mem_data_in <= wdata_q + DATA_W'(1);
                        state_q     <= StSetup;
                    end
                end

                StWait: begin
                    if (wait_q <= 2'd1) begin
                        rsp_rdata <= mem_data_out;
                        rsp_valid <= 1'b1;
                        rsp_last  <= last_beat;
                        state_q   <= StResp;
                    end else begin
                        wait_q <= wait_q - 2'd1;
                    end
                end

                StResp: begin
                    if (!rsp_valid) begin
                        rsp_last  <= 1'b0;
                        req_ready <= 1'b1;
                        busy      <= 1'b0;
                        state_q   <= StIdle;
                    end else if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_last  <= 1'b0;
                        if (last_beat) begin
                            req_ready <= 1'b1;
                            busy      <= 1'b0;
                            state_q   <= StIdle;
                        end else begin
                            beat_q   <= beat_q + 2'd1;
                            addr_q   <= addr_q + ADDR_W'(1);
                            mem_addr <= addr_q + ADDR_W'(1);
                            state_q  <= StSetup;
                        end
                    end
                end

                StWack: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_last  <= 1'b0;
                        req_ready <= 1'b1;
                        busy      <= 1'b0;
                        state_q   <= StIdle;
                    end
                end

                default: begin
                    mem_read_write <= 1'b0;
                    rsp_valid      <= 1'b0;
                    rsp_last       <= 1'b0;
                    req_ready      <= 1'b1;
                    busy           <= 1'b0;
                    state_q        <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomized bench for mem_access_ctrl: a timing/transaction model predicts strobes, responses
// and handshake signals every cycle; directed sequences pin the model with literal values.
module tb_mem_access_ctrl;

    localparam int unsigned RD_LAT = 1;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid, req_ready, req_write;
    logic [4:0] req_addr;
    logic [7:0] req_wdata;
    logic [1:0] req_len;
    logic       rsp_valid, rsp_ready, rsp_last, busy;
    logic [7:0] rsp_rdata;
    logic [4:0] mem_addr;
    logic [7:0] mem_data_in, mem_data_out;
    logic       mem_read_write;

    logic       l3_req_valid, l3_req_ready, l3_req_write;
    logic [4:0] l3_req_addr;
    logic [7:0] l3_req_wdata;
    logic [1:0] l3_req_len;
    logic       l3_rsp_valid, l3_rsp_ready, l3_rsp_last, l3_busy;
    logic [7:0] l3_rsp_rdata;
    logic [4:0] l3_mem_addr;
    logic [7:0] l3_mem_data_in, l3_mem_data_out;
    logic       l3_mem_read_write;

    logic rdy_auto, rdy_manual, rdy_rand;
    int   ready_pct;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   strobes = 0;

    assign rsp_ready = rdy_auto ? rdy_rand : rdy_manual;

    mem_access_ctrl #(.ADDR_W(5), .DATA_W(8), .RD_LAT(RD_LAT)) u_dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_len(req_len),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_last(rsp_last), .busy(busy),
        .mem_addr(mem_addr), .mem_data_in(mem_data_in),
        .mem_read_write(mem_read_write), .mem_data_out(mem_data_out)
    );

    mem_access_ctrl #(.ADDR_W(5), .DATA_W(8), .RD_LAT(3)) u_dut_l3 (
        .clk(clk), .rst(rst),
        .req_valid(l3_req_valid), .req_ready(l3_req_ready), .req_write(l3_req_write),
        .req_addr(l3_req_addr), .req_wdata(l3_req_wdata), .req_len(l3_req_len),
        .rsp_valid(l3_rsp_valid), .rsp_ready(l3_rsp_ready), .rsp_rdata(l3_rsp_rdata),
        .rsp_last(l3_rsp_last), .busy(l3_busy),
        .mem_addr(l3_mem_addr), .mem_data_in(l3_mem_data_in),
        .mem_read_write(l3_mem_read_write), .mem_data_out(l3_mem_data_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // 32x8 memories: one-cycle read for the main DUT, three-stage read for the RD_LAT=3 DUT.
    logic [7:0] mem [32] = '{default: 8'h00};
    logic [7:0] mem_rd;
    always @(posedge clk) begin
        if (mem_read_write === 1'b1) mem[mem_addr] <= mem_data_in;
        mem_rd <= mem[mem_addr];
    end
    assign mem_data_out = mem_rd;

    logic [7:0] mem3 [32] = '{default: 8'h00};
    logic [7:0] p3_0, p3_1, p3_2;
    always @(posedge clk) begin
        if (l3_mem_read_write === 1'b1) mem3[l3_mem_addr] <= l3_mem_data_in;
        p3_0 <= mem3[l3_mem_addr];
        p3_1 <= p3_0;
        p3_2 <= p3_1;
    end
    assign l3_mem_data_out = p3_2;

    always begin
        @(posedge clk);
        #1;
        rdy_rand = ($urandom_range(0, 99) < ready_pct);
    end

    always @(negedge clk) if (mem_read_write === 1'b1) strobes = strobes + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int         at;
        logic [4:0] addr;
        logic [7:0] data;
    } wr_t;
    typedef struct {
        logic [7:0] rdata;
        logic       last;
    } rsp_t;

    wr_t        wr_q[$];
    rsp_t       rsp_q[$];
    logic [7:0] shadow [32] = '{default: 8'h00};
    int         rsp_due = 0;
    bit         active = 0;
    bit         model_on = 0;
    bit         rst_seen = 0;
    bit         m_exp_rw, m_exp_v, m_was_active;

    always @(negedge clk) begin
        if (rst_seen) begin
            check("rst_req_ready", req_ready, 1);
            check("rst_busy", busy, 0);
            check("rst_rsp_valid", rsp_valid, 0);
            check("rst_rsp_rdata", rsp_rdata, 0);
            check("rst_rsp_last", rsp_last, 0);
            check("rst_mem_addr", mem_addr, 0);
            check("rst_mem_data_in", mem_data_in, 0);
            check("rst_mem_read_write", mem_read_write, 0);
        end
        m_exp_v = 1'b0;
        if (model_on) begin
            m_exp_rw = (wr_q.size() != 0) && (wr_q[0].at == cyc);
            check("mem_read_write", mem_read_write, m_exp_rw);
            if (m_exp_rw) begin
                check("strobe_addr", mem_addr, wr_q[0].addr);
                check("strobe_data", mem_data_in, wr_q[0].data);
                shadow[wr_q[0].addr] = wr_q[0].data;
                void'(wr_q.pop_front());
            end
            m_exp_v = (rsp_q.size() != 0) && (cyc >= rsp_due);
            check("rsp_valid", rsp_valid, m_exp_v);
            if (m_exp_v) begin
                check("rsp_rdata", rsp_rdata, rsp_q[0].rdata);
                check("rsp_last", rsp_last, rsp_q[0].last);
            end
            check("busy", busy, active);
            check("req_ready", req_ready, !active);
        end
        rst_seen = (rst === 1'b1);
        if (rst === 1'b1) begin
            wr_q.delete();
            rsp_q.delete();
            active   = 0;
            model_on = 1;
        end else if (model_on) begin
            m_was_active = active;
            if (m_exp_v && rsp_ready) begin
                void'(rsp_q.pop_front());
                if (rsp_q.size() == 0) active = 0;
                else rsp_due = cyc + 2 + RD_LAT;
            end
            if (!m_was_active && req_valid) begin
                active = 1;
                if (req_write) begin
                    for (int i = 0; i <= int'(req_len); i++)
                        wr_q.push_back('{at: cyc + 2 + 2 * i, addr: 5'(int'(req_addr) + i),
                                         data: 8'(int'(req_wdata) + i)});
                    rsp_q.push_back('{rdata: 8'h00, last: 1'b1});
                    rsp_due = cyc + 1 + 2 * (int'(req_len) + 1);
                end else begin
                    for (int i = 0; i <= int'(req_len); i++)
                        rsp_q.push_back('{rdata: shadow[5'(int'(req_addr) + i)],
                                          last: (i == int'(req_len))});
                    rsp_due = cyc + 2 + RD_LAT;
                end
            end
        end
    end

    // ---------------- driver helpers (called just after a rising edge) ----------------
    task automatic send_cmd(input bit w, input logic [4:0] a, input logic [7:0] d,
                            input logic [1:0] len, output int t);
        int n = 0;
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_len = len;
        do begin @(negedge clk); n++; end while (!req_ready && n < 300);
        check("req_accept", req_ready, 1);
        t = cyc;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_addr  = 5'($urandom);
        req_wdata = 8'($urandom);
    endtask

    task automatic get_rsp(input int stall, output logic [7:0] d, output logic l, output int fv);
        int n = 0, held = 0;
        bit seen = 0, done = 0;
        rdy_manual = (stall == 0);
        fv = -1; d = 8'h00; l = 1'b0;
        while (!done && n < 300) begin
            @(negedge clk); n++;
            if (rsp_valid) begin
                if (!seen) begin seen = 1; fv = cyc; end
                if (rsp_ready) begin
                    d = rsp_rdata; l = rsp_last; done = 1;
                end else begin
                    held++;
                    if (held == stall) begin @(posedge clk); #1; rdy_manual = 1'b1; end
                end
            end
        end
        check("rsp_handshake_seen", done, 1);
        @(posedge clk); #1;
        rdy_manual = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin @(negedge clk); n++; end while (busy && n < 500);
        check("idle_reached", busy, 0);
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t, fv, s0, nv;
        logic [7:0] d;
        logic l;
        logic [7:0] exp_burst [4];

        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = 5'd0; req_wdata = 8'd0;
        req_len = 2'd0; rdy_auto = 1'b0; rdy_manual = 1'b0; ready_pct = 100;
        l3_req_valid = 1'b0; l3_req_write = 1'b0; l3_req_addr = 5'd0; l3_req_wdata = 8'd0;
        l3_req_len = 2'd0; l3_rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        // Single write then read back.
        s0 = strobes;
        send_cmd(1'b1, 5'h03, 8'hA5, 2'd0, t);
        get_rsp(0, d, l, fv);
        check("wr1_ack_lat", fv - t, 3);
        check("wr1_ack_rdata", d, 8'h00);
        check("wr1_ack_last", l, 1);
        check("wr1_strobes", strobes - s0, 1);
        send_cmd(1'b0, 5'h03, 8'h00, 2'd0, t);
        get_rsp(0, d, l, fv);
        check("rd1_lat", fv - t, 3);
        check("rd1_rdata", d, 8'hA5);
        check("rd1_last", l, 1);

        // Fill burst across the address and data wrap points.
        s0 = strobes;
        send_cmd(1'b1, 5'h1E, 8'hFE, 2'd3, t);
        get_rsp(0, d, l, fv);
        check("fill_ack_lat", fv - t, 9);
        check("fill_ack_rdata", d, 8'h00);
        check("fill_ack_last", l, 1);
        check("fill_strobes", strobes - s0, 4);

        // Read burst with a 5-cycle stall on the second beat.
        exp_burst = '{8'hFE, 8'hFF, 8'h00, 8'h01};
        s0 = strobes;
        send_cmd(1'b0, 5'h1E, 8'h00, 2'd3, t);
        for (int i = 0; i < 4; i++) begin
            get_rsp((i == 1) ? 5 : 0, d, l, fv);
            if (i == 0) check("rdb_first_lat", fv - t, 3);
            check("rdb_rdata", d, exp_burst[i]);
            check("rdb_last", l, (i == 3));
        end
        check("rdb_strobes", strobes - s0, 0);

        // Reset while the read is waiting on memory data.
        send_cmd(1'b0, 5'h00, 8'h00, 2'd0, t);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rstmid_rsp_valid", rsp_valid, 0);
        check("rstmid_busy", busy, 0);
        check("rstmid_req_ready", req_ready, 1);
        s0 = strobes;
        nv = 0;
        repeat (6) begin @(negedge clk); if (rsp_valid) nv++; end
        check("rstmid_no_rsp", nv, 0);
        check("rstmid_no_strobe", strobes - s0, 0);
        @(posedge clk); #1;
        send_cmd(1'b0, 5'h00, 8'h00, 2'd0, t);
        get_rsp(0, d, l, fv);
        check("rd0_lat", fv - t, 3);
        check("rd0_rdata", d, 8'h00);
        check("rd0_last", l, 1);

        // req_valid held high continuously across bursts.
        rdy_auto = 1'b1;
        ready_pct = 60;
        repeat (120) begin
            req_valid = 1'b1;
            req_write = 1'($urandom);
            req_addr  = 5'($urandom);
            req_wdata = 8'($urandom);
            req_len   = 2'($urandom);
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        wait_idle();

        // Random commands with random gaps and response backpressure.
        repeat (150) begin
            ready_pct = $urandom_range(25, 100);
            send_cmd(1'($urandom), 5'($urandom), 8'($urandom), 2'($urandom), t);
            wait_idle();
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        end
        rdy_auto = 1'b0;

        // RD_LAT=3 instance: write then read back.
        l3_req_valid = 1'b1; l3_req_write = 1'b1; l3_req_addr = 5'h03; l3_req_wdata = 8'hA5;
        l3_req_len = 2'd0;
        nv = 0;
        do begin @(negedge clk); nv++; end while (!l3_req_ready && nv < 50);
        t = cyc;
        @(posedge clk); #1;
        l3_req_valid = 1'b0;
        nv = 0;
        do begin @(negedge clk); nv++; end while (!l3_rsp_valid && nv < 50);
        check("l3_wr_ack_lat", cyc - t, 3);
        check("l3_wr_ack_rdata", l3_rsp_rdata, 8'h00);
        @(posedge clk); #1;
        l3_req_valid = 1'b1; l3_req_write = 1'b0;
        nv = 0;
        do begin @(negedge clk); nv++; end while (!l3_req_ready && nv < 50);
        t = cyc;
        @(posedge clk); #1;
        l3_req_valid = 1'b0;
        nv = 0;
        do begin @(negedge clk); nv++; end while (!l3_rsp_valid && nv < 50);
        check("l3_rd_lat", cyc - t, 5);
        check("l3_rd_rdata", l3_rsp_rdata, 8'hA5);
        check("l3_rd_last", l3_rsp_last, 1);
        @(posedge clk); #1;
        repeat (2) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
